// File: rtl/ifu_ir_buffer_if.sv
// Fetch/AHB/decode signal bundle for the instruction-return buffer.
// The master side is the fetch stage + bus + decode environment; the slave side is the buffer.
interface ifu_ir_buffer_if #(
  parameter int PC_WIDTH = 32
);
  logic                req_valid;
  logic [PC_WIDTH-1:0] req_pc;
  logic                i_hready;
  logic [31:0]         i_hrdata;
  logic [1:0]          i_hresp;
  logic                flush;
  logic                id_ready;
  logic                id_valid;
  logic [31:0]         id_instr;
  logic [PC_WIDTH-1:0] id_pc;
  logic                id_err;
  logic                fetch_stall;

  modport master (
    output req_valid, req_pc, i_hready, i_hrdata, i_hresp, flush, id_ready,
    input  id_valid, id_instr, id_pc, id_err, fetch_stall
  );

  modport slave (
    input  req_valid, req_pc, i_hready, i_hrdata, i_hresp, flush, id_ready,
    output id_valid, id_instr, id_pc, id_err, fetch_stall
  );
endinterface

// File: rtl/ifu_ir_buffer.sv
// Instruction-return stage: tracks the AHB address phase, captures the data beat and queues {instr, pc, err}.
// Optional same-cycle bypass of an incoming beat into an empty queue: define IFU_BUF_BYPASS_EN.
module ifu_ir_buffer #(
  parameter int          PC_WIDTH  = 32,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  ifu_ir_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [31:0]         instr;
    logic [PC_WIDTH-1:0] pc;
    logic                err;
  } entry_t;

  logic                pend_valid_q, pend_valid_d;
  logic                pend_kill_q, pend_kill_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  entry_t              entry_q [DEPTH];
  entry_t              entry_d [DEPTH];

  logic   pend_live;
  logic   stall;
  logic   accept;
  logic   complete;
  logic   live;
  logic   fifo_empty;
  logic   bypass;
  logic   push;
  logic   pop;
  entry_t beat;
  entry_t out_entry;

  // Credit check uses registered state only, so fetch_stall has no path from the bus or decode.
  assign pend_live = pend_valid_q && !pend_kill_q;
  assign stall     = ({1'b0, count_q} + (CW+1)'(pend_live)) >= DEPTH_W;

  always_comb begin
    accept     = bus.req_valid && bus.i_hready && !stall;
    complete   = pend_valid_q && bus.i_hready;
    live       = complete && !pend_kill_q && !bus.flush;
    beat.err   = |bus.i_hresp;
    beat.instr = beat.err ? NOP_INSTR : bus.i_hrdata;
    beat.pc    = pend_pc_q;
    fifo_empty = (count_q == '0);
`ifdef IFU_BUF_BYPASS_EN
    bypass     = fifo_empty && live;
`else
    bypass     = 1'b0;
`endif
    out_entry  = '0;
    if (bypass) begin
      out_entry = beat;
    end else if (!fifo_empty) begin
      out_entry = entry_q[rd_ptr_q];
    end
    pop  = !fifo_empty && bus.id_ready;
    // A bypassed beat taken by decode in the same cycle never enters the queue.
    push = live && !(bypass && bus.id_ready);
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_kill_d  = pend_kill_q;
    pend_pc_d    = pend_pc_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_kill_d  = 1'b0;
      pend_pc_d    = bus.req_pc;
    end else if (complete) begin
      pend_valid_d = 1'b0;
      pend_kill_d  = 1'b0;
    end else if (bus.flush && pend_valid_q) begin
      pend_kill_d  = 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign entry_d[gi] = (push && (wr_ptr_q == AW'(gi))) ? beat : entry_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_kill_q  <= 1'b0;
      pend_pc_q    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_kill_q  <= pend_kill_d;
      pend_pc_q    <= pend_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // The credit scheme must make a push into a full queue without a pop unreachable.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push && !pop && (count_q == CW'(DEPTH))));

  assign bus.id_valid    = !fifo_empty || bypass;
  assign bus.id_instr    = out_entry.instr;
  assign bus.id_pc       = out_entry.pc;
  assign bus.id_err      = out_entry.err;
  assign bus.fetch_stall = stall;

endmodule
